pwm_demod: RTL and testbench

PWM_DEMOD -- requirements
Module: pwm_demod

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_sync.sv | 27 ++
 rtl/pwm_demod.sv | 179 +++++++++++++++++
 tb/tb_pwm_demod.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg -- constants and types shared by the PWM generator and demodulator.
//   PWM_WIDTH     : duty/sample width in bits
//   PWM_PERIOD    : nominal PWM period in clock cycles
//   PER_CNT_W     : period counter width (holds PWM_PERIOD itself without wrap)
//   demod_state_e : demodulator FSM state encoding
//   sat_inc       : saturating increment for duty-width counters
package pwm_pkg;

    localparam int unsigned PWM_WIDTH  = 8;
    localparam int unsigned PWM_PERIOD = 256;
    localparam int unsigned PER_CNT_W  = 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_FLAT    = 2'd2
    } demod_state_e;

    function automatic logic [PWM_WIDTH-1:0] sat_inc(input logic [PWM_WIDTH-1:0] v);
        return (v == {PWM_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pwm_sync.sv
// pwm_sync -- multi-flop synchronizer for an asynchronous single-bit input.
//   clk     : sampling clock
//   rst     : asynchronous active-high reset, clears every stage to 0
//   i_async : asynchronous input
//   o_sync  : input after SYNC_STAGES flops (SYNC_STAGES must be at least 2)
module pwm_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pwm_demod.sv
// pwm_demod -- recovers the duty value of a PWM line of known period.
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   en     : enable; low forces idle and clears tracking (sample is held)
//   pwm_i  : asynchronous PWM input, rising edge marks a period start
//   sample : last recovered duty value (high cycles per period, 0/255 for a flat line)
//   valid  : one-cycle strobe, sample updated this cycle
//   lock   : high after two consecutive valids with no period error in between
//   err    : one-cycle strobe, a rising edge arrived before a full period elapsed
module pwm_demod
    import pwm_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PERIOD      = PWM_PERIOD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 pwm_i,
    output logic [PWM_WIDTH-1:0] sample,
    output logic                 valid,
    output logic                 lock,
    output logic                 err
);

    localparam logic [PER_CNT_W-1:0] PERIOD_CNT = PER_CNT_W'(PERIOD);

    logic                 w_pwm_s;
    logic                 r_pwm_s_d;
    logic [SYNC_STAGES:0] r_fill;
    logic                 w_armed;
    logic                 w_rise;
    logic [PWM_WIDTH-1:0] w_flat_sample;

    demod_state_e         r_state, w_state_d;
    logic [PER_CNT_W-1:0] r_per_cnt, w_per_cnt_d;
    logic [PWM_WIDTH-1:0] r_hi_cnt, w_hi_cnt_d;
    logic [PWM_WIDTH-1:0] r_sample, w_sample_d;
    logic                 r_valid, w_valid_d;
    logic                 r_err, w_err_d;
    logic                 r_lock, w_lock_d;
    logic                 r_have_valid, w_have_valid_d;

    pwm_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_async(pwm_i),
        .o_sync (w_pwm_s)
    );

    // After reset the synchronizer and history flop hold zeros rather than the real
    // line level. r_fill counts the flushing edges so that a line already high at
    // reset release is not mistaken for a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_s_d <= 1'b0;
            r_fill    <= '0;
        end else begin
            r_pwm_s_d <= w_pwm_s;
            r_fill    <= {r_fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_armed       = r_fill[SYNC_STAGES];
    assign w_rise        = w_pwm_s & ~r_pwm_s_d & w_armed;
    assign w_flat_sample = {PWM_WIDTH{w_pwm_s}};

    always_comb begin
        w_state_d      = r_state;
        w_per_cnt_d    = r_per_cnt;
        w_hi_cnt_d     = r_hi_cnt;
        w_sample_d     = r_sample;
        w_valid_d      = 1'b0;
        w_err_d        = 1'b0;
        w_lock_d       = r_lock;
        w_have_valid_d = r_have_valid;

        if (!en) begin
            w_state_d   = ST_IDLE;
            w_per_cnt_d = '0;
            w_hi_cnt_d  = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_per_cnt_d = '0;
                    w_hi_cnt_d  = '0;
                    if (w_rise) begin
                        w_state_d   = ST_MEASURE;
                        w_per_cnt_d = PER_CNT_W'(1);
                        w_hi_cnt_d  = PWM_WIDTH'(1);
                    end
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        // Counters restart at 1: the rise cycle is the first high cycle.
                        if (r_per_cnt == PERIOD_CNT) begin
                            w_sample_d = r_hi_cnt;
                            w_valid_d  = 1'b1;
                        end else begin
                            w_err_d = 1'b1;
                        end
                        w_per_cnt_d = PER_CNT_W'(1);
                        w_hi_cnt_d  = PWM_WIDTH'(1);
                    end else if (r_per_cnt == PERIOD_CNT) begin
                        // A full period with no new edge: the line is stuck at a level.
                        w_state_d   = ST_FLAT;
                        w_sample_d  = w_flat_sample;
                        w_valid_d   = 1'b1;
                        w_per_cnt_d = PER_CNT_W'(1);
                        w_hi_cnt_d  = '0;
                    end else begin
                        w_per_cnt_d = r_per_cnt + 1'b1;
                        if (w_pwm_s) begin
                            w_hi_cnt_d = sat_inc(r_hi_cnt);
                        end
                    end
                end
                ST_FLAT: begin
                    if (w_rise) begin
                        w_state_d   = ST_MEASURE;
                        w_per_cnt_d = PER_CNT_W'(1);
                        w_hi_cnt_d  = PWM_WIDTH'(1);
                    end else if (r_per_cnt == PERIOD_CNT) begin
                        w_sample_d  = w_flat_sample;
                        w_valid_d   = 1'b1;
                        w_per_cnt_d = PER_CNT_W'(1);
                    end else begin
                        w_per_cnt_d = r_per_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_d   = ST_IDLE;
                    w_per_cnt_d = '0;
                    w_hi_cnt_d  = '0;
                end
            endcase
        end

        if (!en || w_err_d) begin
            w_lock_d       = 1'b0;
            w_have_valid_d = 1'b0;
        end else if (w_valid_d) begin
            if (r_have_valid) begin
                w_lock_d = 1'b1;
            end
            w_have_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_per_cnt    <= '0;
            r_hi_cnt     <= '0;
            r_sample     <= '0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_lock       <= 1'b0;
            r_have_valid <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_per_cnt    <= w_per_cnt_d;
            r_hi_cnt     <= w_hi_cnt_d;
            r_sample     <= w_sample_d;
            r_valid      <= w_valid_d;
            r_err        <= w_err_d;
            r_lock       <= w_lock_d;
            r_have_valid <= w_have_valid_d;
        end
    end

    assign sample = r_sample;
    assign valid  = r_valid;
    assign lock   = r_lock;
    assign err    = r_err;

endmodule

// File: tb/tb_pwm_demod.sv
// tb_pwm_demod -- directed bench for pwm_demod with a timestamp-based reference model.
module tb_pwm_demod;

    localparam int S    = 2;
    localparam int P    = 256;
    localparam int HIST = 32768;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       pwm_i;
    logic [7:0] sample;
    logic       valid;
    logic       lock;
    logic       err;

    pwm_demod #(
        .SYNC_STAGES(S),
        .PERIOD     (P)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .pwm_i (pwm_i),
        .sample(sample),
        .valid (valid),
        .lock  (lock),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    // ---------------- reference model ----------------
    // Works on edge timestamps: the demodulator sees pwm_i delayed by S edges, a rise
    // is a 0->1 step of that delayed line (only once the delay line holds real data),
    // and events follow from the spacing between rises.
    int g     = 0;   // clock edges so far
    int g_rel = 0;   // first edge after the latest reset release
    bit px[HIST];    // pwm_i sampled at each edge
    bit sh[HIST];    // line as seen by the demodulator at each edge
    bit m_valid, m_err, m_lock, m_have_prev;
    int m_prev, m_nval, m_sample;

    function automatic bit line_at(input int e);
        if (e - S >= g_rel) return px[e-S];
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model
        bit s, rise;
        int sum;
        if (g < HIST) px[g] = pwm_i;
        if (rst) begin
            g_rel       = g + 1;
            m_have_prev = 1'b0;
            m_nval      = 0;
            m_valid     = 1'b0;
            m_err       = 1'b0;
            m_lock      = 1'b0;
            m_sample    = 0;
        end else begin
            s    = line_at(g);
            rise = (g - S - 1 >= g_rel) && s && !line_at(g - 1);
            if (g < HIST) sh[g] = s;
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (!en) begin
                m_have_prev = 1'b0;
                m_nval      = 0;
                m_lock      = 1'b0;
            end else if (rise) begin
                if (m_have_prev) begin
                    if (g - m_prev < P) begin
                        m_err  = 1'b1;
                        m_nval = 0;
                        m_lock = 1'b0;
                    end else if (g - m_prev == P) begin
                        sum = 0;
                        for (int i = m_prev; i < g; i++) sum += int'(sh[i]);
                        m_valid  = 1'b1;
                        m_sample = (sum > 255) ? 255 : sum;
                    end
                end
                m_have_prev = 1'b1;
                m_prev      = g;
            end else if (m_have_prev && g > m_prev && ((g - m_prev) % P) == 0) begin
                m_valid  = 1'b1;
                m_sample = s ? 255 : 0;
            end
            if (m_valid) begin
                m_nval++;
                if (m_nval >= 2) m_lock = 1'b1;
            end
        end
        g++;
    end

    // ---------------- per-cycle compare and event log ----------------
    int nv = 0;
    int ne = 0;
    int vq[$];   // sample at each valid
    int vg[$];   // edge count at each valid
    int lq[$];   // lock at each valid
    int rq[$];   // edge count at which each rising edge of pwm_i was driven
    int eq[$];   // expected sample sequence for the current phase

    always @(negedge clk) begin : compare
        logic [10:0] e_bits;
        logic [10:0] a_bits;
        e_bits = rst ? 11'd0 : {m_valid, m_err, m_lock, 8'(m_sample)};
        a_bits = {valid, err, lock, sample};
        n_checks++;
        if (a_bits === e_bits) n_pass++;
        else $display("FAIL model edge %0d: got v/e/l/sample=%b/%b/%b/%0d, required %b/%b/%b/%0d",
                      g, a_bits[10], a_bits[9], a_bits[8], a_bits[7:0],
                      e_bits[10], e_bits[9], e_bits[8], e_bits[7:0]);
        if (!rst) begin
            if (valid === 1'b1) begin
                nv++;
                vq.push_back(int'(sample));
                vg.push_back(g);
                lq.push_back(int'(lock));
            end
            if (err === 1'b1) ne++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input bit v);
        @(negedge clk);
        if (v && !pwm_i) rq.push_back(g);
        pwm_i = v;
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    task automatic wave(input int n, input int per, input int duty);
        for (int k = 0; k < n; k++)
            for (int c = 0; c < per; c++) tick(c < duty);
    endtask

    // Rising edge that closes the last period, then let the pipeline settle.
    task automatic close_wave();
        tick(1'b1);
        hold(1'b0, 8);
    endtask

    task automatic clear_log();
        nv = 0;
        ne = 0;
        vq.delete();
        vg.delete();
        lq.delete();
        rq.delete();
    endtask

    task automatic new_phase();
        @(negedge clk);
        en    = 1'b0;
        pwm_i = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (4) @(negedge clk);
        clear_log();
    endtask

    task automatic check_seq(input string name);
        check({name, " valid count"}, vq.size(), eq.size());
        for (int i = 0; i < eq.size() && i < vq.size(); i++)
            check($sformatf("%s sample[%0d]", name, i), vq[i], eq[i]);
    endtask

    task automatic check_gap(input string name, input int a_idx, input int b_edge, input int req);
        if (a_idx < vg.size()) check(name, vg[a_idx] - b_edge, req);
        else check({name, " (valid missing)"}, vg.size(), a_idx + 1);
    endtask

    int nv_before, ne_before, mark;

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        pwm_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset sample", int'(sample), 0);
        check("reset valid", int'(valid), 0);
        check("reset lock", int'(lock), 0);
        check("reset err", int'(err), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        clear_log();

        // A: steady 130/256 -> five valids of 130, lock from the second valid.
        wave(5, P, 130);
        close_wave();
        eq = {130, 130, 130, 130, 130};
        check_seq("A");
        check("A errs", ne, 0);
        check("A lock end", int'(lock), 1);
        if (lq.size() >= 2) begin
            check("A lock at 1st valid", lq[0], 0);
            check("A lock at 2nd valid", lq[1], 1);
        end else check("A lock history size", lq.size(), 2);
        if (rq.size() >= 1) check_gap("A first valid latency", 0, rq[0], P + S + 1);
        else check("A rises driven", rq.size(), 1);

        // B: duty 100 then 26 at a period boundary.
        new_phase();
        wave(2, P, 100);
        wave(2, P, 26);
        close_wave();
        eq = {100, 100, 26, 26};
        check_seq("B");
        check("B errs", ne, 0);
        if (lq.size() >= 4) begin
            check("B lock at 3rd valid", lq[2], 1);
            check("B lock at 4th valid", lq[3], 1);
        end else check("B lock history size", lq.size(), 4);

        // C: line flat low, flat high, then wave returns. The period that ends as the
        // line goes flat reports at its boundary, so 600 low cycles give three zeros.
        new_phase();
        wave(2, P, 130);
        hold(1'b0, 600);
        hold(1'b1, 600);
        hold(1'b0, 10);
        wave(3, P, 26);
        close_wave();
        eq = {130, 0, 0, 0, 255, 255, 26, 26, 26};
        check_seq("C");
        check("C errs", ne, 0);
        check("C lock end", int'(lock), 1);
        if (vg.size() >= 6) begin
            check("C low spacing", vg[2] - vg[1], P);
            check("C high spacing", vg[5] - vg[4], P);
        end else check("C valid times", vg.size(), 6);

        // D: lock on 256, then 200-cycle periods -> errors only, sample held.
        new_phase();
        wave(3, P, 50);
        wave(6, 200, 50);
        close_wave();
        eq = {50, 50, 50};
        check_seq("D");
        check("D errs", ne, 6);
        check("D lock end", int'(lock), 0);
        check("D sample held", int'(sample), 50);
        if (lq.size() >= 3) check("D lock before errs", lq[2], 1);
        else check("D lock history size", lq.size(), 3);

        // E: asynchronous reset while the line is high mid-period.
        new_phase();
        wave(2, P, 130);
        for (int c = 0; c < 100; c++) tick(c < 130);
        check("E sample before rst", int'(sample), 130);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("E rst sample", int'(sample), 0);
        check("E rst valid", int'(valid), 0);
        check("E rst lock", int'(lock), 0);
        check("E rst err", int'(err), 0);
        clear_log();
        for (int c = 100; c < 102; c++) tick(c < 130);
        rst = 1'b0;
        for (int c = 102; c < P; c++) tick(c < 130);
        wave(2, P, 130);
        close_wave();
        eq = {130, 130};
        check_seq("E");
        check("E errs", ne, 0);
        if (rq.size() >= 1) check_gap("E first valid after reset", 0, rq[0], P + S + 1);
        else check("E rises driven", rq.size(), 1);

        // F: en low for 10 cycles mid-period.
        new_phase();
        wave(3, P, 130);
        for (int c = 0; c < 100; c++) tick(c < 130);
        check("F lock before en low", int'(lock), 1);
        en        = 1'b0;
        nv_before = nv;
        ne_before = ne;
        for (int c = 100; c < 110; c++) tick(c < 130);
        check("F lock en low", int'(lock), 0);
        check("F valids while en low", nv - nv_before, 0);
        check("F errs while en low", ne - ne_before, 0);
        en = 1'b1;
        for (int c = 110; c < P; c++) tick(c < 130);
        mark = rq.size();
        wave(2, P, 130);
        close_wave();
        check("F valids before en low", nv_before, 3);
        check("F valids total", nv, 5);
        check("F errs", ne, 0);
        check("F sample", int'(sample), 130);
        if (rq.size() > mark) check_gap("F first valid after en", nv_before, rq[mark], P + S + 1);
        else check("F rises after en", rq.size(), mark + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
